wac_adc_capture: RTL and testbench
==================================

// Module: wac_adc_capture
// PURPOSE
//  Parametrised N-channel serial-ADC capture engine; successor to the fixed two-ADC readout (CSADC1/2, CLKADC1/2).
//  Runs shared CS/SCLK frames and shifts in all SDO lines in parallel.
//  Writes each sample as two bytes, high byte first, into the byte-wide BRAM port read back over EPP.
//  Supports single-shot (N frames) and continuous modes with a frame-boundary stop.
// PARAMETERS
//  N_CH       2   number of ADC channels (1..8)
//  SAMPLE_W   12  data bits per sample, taken from the last SAMPLE_W bits of the frame (<=16)
//  FRAME_BITS 16  SCLK periods per conversion frame
//  CLK_DIV    2   clk cycles per SCLK half-period (>=1)
//  QUIET_CYC  4   CS-high clk cycles between frames (>=1)
//  ADDR_W     12  BRAM byte-address width
// PORTS
//  clk          in   1         system clock
//  rst          in   1         synchronous reset, active high
//  start        in   1         1-cycle pulse; accepted only in IDLE
//  stop         in   1         level or pulse; latched, honoured at next frame boundary
//  contMode     in   1         1 = continuous, ignores nFrames; sampled at start
//  nFrames      in   16        frames to capture in single-shot mode; sampled at start
//  baseAddr     in   ADDR_W    first BRAM byte address; sampled at start
//  sdoAdc       in   N_CH      ADC serial data, bit i = channel i
//  csAdc        out  1         shared ADC chip select, active low
//  clkAdc       out  1         shared SCLK, idles high
//  busBramAddr  out  ADDR_W    BRAM write address
//  busBramOut   out  8         BRAM write data
//  ctrlWeBram   out  1         BRAM write enable, 1 byte per cycle
//  busy         out  1         high from cycle after start accepted until DONE
//  done         out  1         1-cycle pulse when the run ends
//  frameCnt     out  16        completed frames in the current run
// BEHAVIOUR
//  Reset: state IDLE; csAdc=1, clkAdc=1, ctrlWeBram=0, busBramAddr=0, busBramOut=0, busy=0, done=0, frameCnt=0, stop latch cleared.
//  Reset mid-run: takes effect on the same edge; the partial frame is discarded and no write is issued.
//  States: IDLE -> CONV -> WRITE -> QUIET -> (CONV | DONE) -> IDLE.
//  IDLE: on start, latch contMode, nFrames and baseAddr.
//    If single-shot with nFrames=0, go to DONE with no CS activity.
//    Otherwise go to CONV; csAdc falls on the first clk edge after start.
//  CONV: lasts FRAME_BITS*2*CLK_DIV cycles.
//    Each SCLK period is CLK_DIV cycles low, then CLK_DIV cycles high.
//    All sdoAdc bits shift in, MSB first, on the clk edge where clkAdc goes 0->1.
//  WRITE: csAdc=1, clkAdc=1; lasts 2*N_CH cycles with ctrlWeBram=1 each cycle.
//    Write order: ch0 hi, ch0 lo, ch1 hi, ...
//    hi byte = sample[15:8], zero-extended to 16 bits.
//  Address: increments by 1 per byte written; wraps modulo 2^ADDR_W with no flag.
//  QUIET: QUIET_CYC cycles. frameCnt increments on entry; it saturates at 0xFFFF.
//    Leave to DONE if the stop latch is set, or if single-shot and frameCnt==nFrames; otherwise go to CONV.
//  Frame period = FRAME_BITS*2*CLK_DIV + 2*N_CH + QUIET_CYC cycles (72 with defaults).
//  DONE: lasts 1 cycle. done=1, busy falls on the next edge, then IDLE.
//  stop during CONV or WRITE: the frame completes fully, including its writes.
//  stop together with start in IDLE: start accepted, one frame captured.
//  start while busy: ignored; latched values do not change.
// CONFIGURATION
//  ADC_TESTPAT_EN defined: a testPat input (1 bit) exists.
//    When testPat=1 at start, sdoAdc is ignored for the run.
//    Each channel's sample = {channel index[3:0], frameCnt[7:0]} truncated to SAMPLE_W bits.
//    CS and SCLK timing are unchanged.
//  ADC_TESTPAT_EN undefined: no testPat port; samples always come from sdoAdc.
// STRUCTURE
//  Package wac_adc_pkg:
//    state encoding (IDLE, CONV, WRITE, QUIET, DONE);
//    derived constants CONV_CYC and WR_CYC;
//    function clog2 for counter widths.
//  Sub-module wac_adc_shift: one per channel via generate.
//    FRAME_BITS shift register with shift enable.
//    Parallel output of the low SAMPLE_W bits.
//  Top level holds the FSM, SCLK divider, byte mux and address counter.
// TESTING
//  1 sdoAdc=2'b01 constant, nFrames=1, base=0
//    -> 4 writes: addr 0..3, data 0x0F, 0xFF, 0x00, 0x00; done after 72+1 cycles.
//  2 ch0 model shifts 16-bit word 0x0A5C
//    -> bytes 0x0A, 0x5C; exactly 16 clkAdc rising edges per CS-low window.
//  3 nFrames=3, base=0xFFE
//    -> 12 writes; addresses 0xFFE, 0xFFF, 0x000 ... 0x009; frameCnt=3; one done pulse.
//  4 start while busy; rst asserted at CONV cycle 20
//    -> start ignored; csAdc=1, busy=0, and no ctrlWeBram on the edge after rst.
//  5 nFrames=0
//    -> done one cycle after start; csAdc never low; no writes.
//  6 contMode=1, stop pulsed mid-CONV of frame 5
//    -> frame 5 written (20 bytes total), then DONE; frameCnt=5.

Source files
------------

// File: rtl/wac_adc_pkg.sv
// Shared definitions for the N-channel serial-ADC capture engine.
// Contents:
//   state_e  - capture FSM state encoding
//   clog2    - ceil(log2) helper for counter widths (never returns less than 1)
//   conv_cyc - clk cycles in one CS-low conversion frame
//   wr_cyc   - clk cycles (one byte each) spent writing a frame to BRAM
package wac_adc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StWrite,
    StQuiet,
    StDone
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    return (res == 0) ? 1 : res;
  endfunction

  function automatic int unsigned conv_cyc(input int unsigned frame_bits,
                                           input int unsigned clk_div);
    return frame_bits * 2 * clk_div;
  endfunction

  function automatic int unsigned wr_cyc(input int unsigned n_ch);
    return 2 * n_ch;
  endfunction

endpackage

// File: rtl/wac_adc_shift.sv
// Per-channel serial-in shift register for the ADC capture engine.
// Ports:
//   clk_i      - system clock
//   rst_i      - synchronous reset, active high
//   shift_en_i - shift one bit in (asserted on the SCLK rising edge)
//   sdo_i      - ADC serial data, MSB first
//   sample_o   - the last SAMPLE_W bits shifted in
module wac_adc_shift #(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned SAMPLE_W   = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                shift_en_i,
  input  logic                sdo_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  logic [FRAME_BITS-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_en_i) begin
      sr_d = (sr_q << 1) | FRAME_BITS'(sdo_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sample_o = sr_q[SAMPLE_W-1:0];

  // Leading frame bits (ADC header/zeros) are shifted through but never used.
  if (FRAME_BITS > SAMPLE_W) begin : g_hi_unused
    logic unused_hi;
    assign unused_hi = ^sr_q[FRAME_BITS-1:SAMPLE_W];
  end

endmodule

// File: rtl/wac_adc_capture.sv
// N-channel serial-ADC capture engine. Runs shared CS/SCLK frames, shifts all
// SDO lines in parallel and writes each sample as two bytes (high first) into
// a byte-wide BRAM port. Single-shot (nFrames) and continuous modes, with a
// stop request honoured at the next frame boundary.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, stop              - run start pulse (IDLE only), stop request
//   contMode, nFrames        - run mode and frame count, sampled at start
//   baseAddr                 - first BRAM byte address, sampled at start
//   sdoAdc                   - ADC serial data, bit i = channel i
//   csAdc, clkAdc            - shared chip select (active low) and SCLK
//   busBramAddr/Out, ctrlWeBram - BRAM byte write port
//   busy, done, frameCnt     - run status
// Build option: define ADC_TESTPAT_EN to add the testPat input; when high at
// start, samples become {channel[3:0], frameCnt[7:0]} instead of sdoAdc.
module wac_adc_capture
  import wac_adc_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned SAMPLE_W   = 12,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned QUIET_CYC  = 4,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              contMode,
  input  logic [15:0]       nFrames,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [N_CH-1:0]   sdoAdc,
`ifdef ADC_TESTPAT_EN
  input  logic              testPat,
`endif
  output logic              csAdc,
  output logic              clkAdc,
  output logic [ADDR_W-1:0] busBramAddr,
  output logic [7:0]        busBramOut,
  output logic              ctrlWeBram,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frameCnt
);

  localparam int unsigned ConvCyc = conv_cyc(FRAME_BITS, CLK_DIV);
  localparam int unsigned WrCyc   = wr_cyc(N_CH);
  localparam int unsigned MaxA    = (ConvCyc > WrCyc) ? ConvCyc : WrCyc;
  localparam int unsigned CntMax  = (MaxA > QUIET_CYC) ? MaxA : QUIET_CYC;
  localparam int unsigned CntW    = clog2(CntMax);
  localparam int unsigned PhW     = clog2(2 * CLK_DIV);

  localparam logic [CntW-1:0] ConvLast  = CntW'(ConvCyc - 1);
  localparam logic [CntW-1:0] WrLast    = CntW'(WrCyc - 1);
  localparam logic [CntW-1:0] QuietLast = CntW'(QUIET_CYC - 1);
  localparam logic [PhW-1:0]  PhLast    = PhW'(2 * CLK_DIV - 1);
  localparam logic [PhW-1:0]  PhHigh    = PhW'(CLK_DIV);
  localparam logic [PhW-1:0]  PhRise    = PhW'(CLK_DIV - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PhW-1:0]    ph_q, ph_d;
  logic              cont_q, cont_d;
  logic [15:0]       nframes_q, nframes_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic              stop_q, stop_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [7:0]        bram_data_q, bram_data_d;
`ifdef ADC_TESTPAT_EN
  logic              testpat_q, testpat_d;
  localparam logic [15:0] SampleMask = 16'((32'd1 << SAMPLE_W) - 1);
`endif

  logic                 shift_en;
  logic [N_CH-1:0][15:0] sample_ext;

  // Shift on the clk edge where SCLK goes 0->1.
  assign shift_en = (state_q == StConv) && (ph_q == PhRise);

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    logic [SAMPLE_W-1:0] shreg_sample;

    wac_adc_shift #(
      .FRAME_BITS (FRAME_BITS),
      .SAMPLE_W   (SAMPLE_W)
    ) u_shift (
      .clk_i      (clk),
      .rst_i      (rst),
      .shift_en_i (shift_en),
      .sdo_i      (sdoAdc[i]),
      .sample_o   (shreg_sample)
    );

`ifdef ADC_TESTPAT_EN
    logic [15:0] pat;
    assign pat           = {4'b0000, 4'(i), frame_cnt_q[7:0]} & SampleMask;
    assign sample_ext[i] = testpat_q ? pat : 16'(shreg_sample);
`else
    assign sample_ext[i] = 16'(shreg_sample);
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ph_d        = ph_q;
    cont_d      = cont_q;
    nframes_d   = nframes_q;
    addr_ptr_d  = addr_ptr_q;
    stop_d      = stop_q;
    frame_cnt_d = frame_cnt_q;
    busy_d      = busy_q;
    bram_addr_d = bram_addr_q;
    bram_data_d = bram_data_q;
`ifdef ADC_TESTPAT_EN
    testpat_d   = testpat_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cont_d      = contMode;
          nframes_d   = nFrames;
          addr_ptr_d  = baseAddr;
          stop_d      = stop;
          frame_cnt_d = '0;
          busy_d      = 1'b1;
          cnt_d       = '0;
          ph_d        = '0;
`ifdef ADC_TESTPAT_EN
          testpat_d   = testPat;
`endif
          state_d     = (!contMode && nFrames == 16'd0) ? StDone : StConv;
        end
      end
      StConv: begin
        stop_d = stop_q | stop;
        ph_d   = (ph_q == PhLast) ? '0 : ph_q + PhW'(1);
        if (cnt_q == ConvLast) begin
          cnt_d   = '0;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrite: begin
        stop_d = stop_q | stop;
        if (cnt_q == WrLast) begin
          cnt_d       = '0;
          state_d     = StQuiet;
          frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StQuiet: begin
        stop_d = stop_q | stop;
        if (cnt_q == QuietLast) begin
          cnt_d = '0;
          ph_d  = '0;
          if (stop_d || (!cont_q && frame_cnt_q == nframes_q)) begin
            state_d = StDone;
          end else begin
            state_d = StConv;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        stop_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered: derive them from the next state.
    cs_d   = (state_d != StConv);
    sclk_d = (state_d != StConv) || (ph_d >= PhHigh);
    done_d = (state_d == StDone);
    we_d   = (state_d == StWrite);
    if (state_d == StWrite) begin
      bram_addr_d = addr_ptr_q;
      addr_ptr_d  = addr_ptr_q + ADDR_W'(1);
      // Byte k of the frame: channel k/2, high byte on even k.
      for (int i = 0; i < int'(N_CH); i++) begin
        if (i == int'(cnt_d) / 2) begin
          bram_data_d = cnt_d[0] ? sample_ext[i][7:0] : sample_ext[i][15:8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ph_q        <= '0;
      cont_q      <= 1'b0;
      nframes_q   <= '0;
      addr_ptr_q  <= '0;
      stop_q      <= 1'b0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b1;
      we_q        <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
`ifdef ADC_TESTPAT_EN
      testpat_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      cont_q      <= cont_d;
      nframes_q   <= nframes_d;
      addr_ptr_q  <= addr_ptr_d;
      stop_q      <= stop_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      we_q        <= we_d;
      bram_addr_q <= bram_addr_d;
      bram_data_q <= bram_data_d;
`ifdef ADC_TESTPAT_EN
      testpat_q   <= testpat_d;
`endif
    end
  end

  assign csAdc       = cs_q;
  assign clkAdc      = sclk_q;
  assign busBramAddr = bram_addr_q;
  assign busBramOut  = bram_data_q;
  assign ctrlWeBram  = we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frameCnt    = frame_cnt_q;

endmodule

// File: tb/tb_wac_adc_capture.sv
// Bench for wac_adc_capture (default build). An ADC model serves one word per
// channel per CS-low window and pushes the expected BRAM writes into a queue;
// a monitor pops and compares on every ctrlWeBram cycle.
module tb_wac_adc_capture;

  localparam int NCh       = 2;
  localparam int SampleW   = 12;
  localparam int FrameBits = 16;
  localparam int ClkDiv    = 2;
  localparam int QuietCyc  = 4;
  localparam int AddrW     = 12;
  localparam int FramePer  = FrameBits * 2 * ClkDiv + 2 * NCh + QuietCyc;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             contMode = 1'b0;
  logic [15:0]      nFrames = '0;
  logic [AddrW-1:0] baseAddr = '0;
  logic [NCh-1:0]   sdoAdc = '0;
  logic             csAdc, clkAdc, ctrlWeBram, busy, done;
  logic [AddrW-1:0] busBramAddr;
  logic [7:0]       busBramOut;
  logic [15:0]      frameCnt;

  int checks = 0;
  int errors = 0;
  int cs_falls = 0;
  int cs_low_cyc = 0;
  int sclk_rises = 0;
  int wr_count = 0;
  int done_count = 0;
  int unsigned exp_addr = 0;
  bit force_en = 1'b0;
  logic [FrameBits-1:0] force_word [NCh];
  logic [FrameBits-1:0] word [NCh];
  wr_t exp_q [$];

  wac_adc_capture #(
    .N_CH       (NCh),
    .SAMPLE_W   (SampleW),
    .FRAME_BITS (FrameBits),
    .CLK_DIV    (ClkDiv),
    .QUIET_CYC  (QuietCyc),
    .ADDR_W     (AddrW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .contMode    (contMode),
    .nFrames     (nFrames),
    .baseAddr    (baseAddr),
    .sdoAdc      (sdoAdc),
    .csAdc       (csAdc),
    .clkAdc      (clkAdc),
    .busBramAddr (busBramAddr),
    .busBramOut  (busBramOut),
    .ctrlWeBram  (ctrlWeBram),
    .busy        (busy),
    .done        (done),
    .frameCnt    (frameCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC model: new word per channel on each CS fall, next bit after each SCLK rise.
  initial begin : adc_model
    bit prev_cs;
    bit prev_sclk;
    int unsigned sample;
    prev_cs = 1'b1;
    prev_sclk = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cs = 1'b1;
        prev_sclk = 1'b1;
        cs_low_cyc = 0;
        sdoAdc = '0;
      end else begin
        if (prev_cs && !csAdc) begin
          cs_falls++;
          cs_low_cyc = 0;
          sclk_rises = 0;
          for (int ch = 0; ch < NCh; ch++) begin
            word[ch] = force_en ? force_word[ch] : FrameBits'($urandom);
            sample = int'(word[ch]) % (1 << SampleW);
            exp_q.push_back('{addr: exp_addr % (1 << AddrW), data: sample / 256});
            exp_addr++;
            exp_q.push_back('{addr: exp_addr % (1 << AddrW), data: sample % 256});
            exp_addr++;
          end
        end
        if (!csAdc) begin
          cs_low_cyc++;
          if (!prev_sclk && clkAdc) sclk_rises++;
        end
        if (!prev_cs && csAdc) chk("sclk_rises_per_frame", sclk_rises, FrameBits);
        for (int ch = 0; ch < NCh; ch++) begin
          sdoAdc[ch] = (!csAdc && sclk_rises < FrameBits) ?
                       word[ch][FrameBits-1-sclk_rises] : 1'b0;
        end
        prev_cs = csAdc;
        prev_sclk = clkAdc;
      end
    end
  end

  // Write monitor / scoreboard.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && ctrlWeBram) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   busBramAddr, busBramOut);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(busBramAddr), e.addr);
          chk("wr_data", 32'(busBramOut), e.data);
        end
      end
      if (!rst && done) done_count++;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run(input bit cont, input int nfr, input int base, input int stop_frame,
                     input int poke, input string tag);
    int n;
    int falls0;
    int wr0;
    int dc0;
    int exp_frames;
    bit stop_sent;
    exp_frames = cont ? stop_frame : nfr;
    stop_sent = 1'b0;
    @(negedge clk);
    contMode = cont;
    nFrames = 16'(nfr);
    baseAddr = AddrW'(base);
    start = 1'b1;
    exp_addr = base;
    falls0 = cs_falls;
    wr0 = wr_count;
    dc0 = done_count;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (poke != 0 && n == poke) begin
        start = 1'b1;
        contMode = ~cont;
        nFrames = 16'd7;
        baseAddr = 12'h500;
      end else if (poke != 0 && n == poke + 1) begin
        start = 1'b0;
      end
      if (stop) begin
        stop = 1'b0;
      end else if (stop_frame != 0 && !stop_sent && cs_falls - falls0 == stop_frame &&
                   !csAdc && cs_low_cyc >= 20) begin
        stop = 1'b1;
        stop_sent = 1'b1;
      end
    end
    chk({tag, "_done_latency"}, n, exp_frames * FramePer + 1);
    chk({tag, "_frameCnt"}, 32'(frameCnt), exp_frames);
    chk({tag, "_write_count"}, wr_count - wr0, exp_frames * 2 * NCh);
    chk({tag, "_cs_windows"}, cs_falls - falls0, exp_frames);
    @(negedge clk);
    chk({tag, "_busy_after_done"}, 32'(busy), 0);
    chk({tag, "_done_single_pulse"}, 32'(done), 0);
    chk({tag, "_done_count"}, done_count - dc0, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int k;
    repeat (3) @(negedge clk);
    chk("rst_csAdc", 32'(csAdc), 1);
    chk("rst_clkAdc", 32'(clkAdc), 1);
    chk("rst_we", 32'(ctrlWeBram), 0);
    chk("rst_addr", 32'(busBramAddr), 0);
    chk("rst_data", 32'(busBramOut), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_frameCnt", 32'(frameCnt), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ch0 all ones, ch1 all zeros
    force_en = 1'b1;
    force_word[0] = 16'hFFFF;
    force_word[1] = 16'h0000;
    run(1'b0, 1, 0, 0, 0, "t1");

    force_word[0] = 16'h0A5C;
    force_word[1] = 16'h9E31;
    run(1'b0, 1, 12'h040, 0, 0, "t2");

    force_en = 1'b0;
    run(1'b0, 3, 12'hFFE, 0, 0, "t3_wrap");

    // start while busy must not disturb the run
    run(1'b0, 2, 12'h100, 0, 10, "t4_start_busy");

    // reset in the middle of a conversion frame
    @(negedge clk);
    contMode = 1'b0;
    nFrames = 16'd2;
    baseAddr = 12'h200;
    exp_addr = 12'h200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(csAdc == 1'b0 && cs_low_cyc == 20) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("t4_reach_conv20", 32'(k < 500), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_csAdc", 32'(csAdc), 1);
    chk("t4_rst_clkAdc", 32'(clkAdc), 1);
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_we", 32'(ctrlWeBram), 0);
    chk("t4_rst_frameCnt", 32'(frameCnt), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    wr_count = 0;
    repeat (2 * FramePer) @(negedge clk);
    chk("t4_no_writes_after_rst", wr_count, 0);
    chk("t4_idle_csAdc", 32'(csAdc), 1);

    run(1'b0, 0, 12'h300, 0, 0, "t5_zero_frames");

    run(1'b1, 0, 12'h010, 5, 0, "t6_cont_stop");

    for (int r = 0; r < 3; r++) begin
      run(1'b0, int'($urandom_range(1, 3)), int'($urandom_range(0, 4095)), 0, 0, "rand");
    end
    run(1'b1, 0, int'($urandom_range(0, 4095)), int'($urandom_range(1, 3)), 0, "rand_cont");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
